// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the 16-bit single-cycle mips core
// Purpose: opcode and funct codes, ALU operation enum, instruction field widths
//          and the immediate sign-extension helper used by mips and mips_alu.
// Ports:   none (package).
package mips_pkg;

  localparam int DATA_W  = 16;
  localparam int OP_W    = 3;
  localparam int REG_W   = 3;
  localparam int FUNCT_W = 3;
  localparam int IMM_W   = 7;
  localparam int JADDR_W = 13;

  localparam logic [OP_W-1:0] OP_RTYPE = 3'b000;
  localparam logic [OP_W-1:0] OP_ADDI  = 3'b001;
  localparam logic [OP_W-1:0] OP_LW    = 3'b010;
  localparam logic [OP_W-1:0] OP_SW    = 3'b011;
  localparam logic [OP_W-1:0] OP_BEQ   = 3'b100;
  localparam logic [OP_W-1:0] OP_J     = 3'b101;
  localparam logic [OP_W-1:0] OP_SLTI  = 3'b110;
  localparam logic [OP_W-1:0] OP_NOP   = 3'b111;

  localparam logic [FUNCT_W-1:0] FN_ADD = 3'b000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 3'b001;
  localparam logic [FUNCT_W-1:0] FN_AND = 3'b010;
  localparam logic [FUNCT_W-1:0] FN_OR  = 3'b011;
  localparam logic [FUNCT_W-1:0] FN_SLT = 3'b100;
  localparam logic [FUNCT_W-1:0] FN_XOR = 3'b101;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_SLT   = 3'd4,
    ALU_XOR   = 3'd5,
    ALU_PASS0 = 3'd6
  } alu_op_t;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - combinational 16-bit ALU of the mips core
// Purpose: computes result = a <op> b for the seven ALU operations.
// Ports:   a, b    in  16  operands
//          alu_op  in  3   operation (alu_op_t encoding)
//          result  out 16  operation result; PASS0 yields 0
//          zero    out 1   result == 0 (BEQ equality test after SUB)
module mips_alu
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        alu_op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips.sv
// rtl/mips.sv - 16-bit single-cycle MIPS-style core with ROM, RAM and register file
// Purpose: fetches, executes and writes back one instruction per clock.
//          IMEM_INIT holds the ROM image, word i at bits [16*i+15:16*i].
// Ports:   clk      in  1   rising-edge clock
//          rst      in  1   asynchronous active-high reset (clears pc, registers, RAM)
//          pc_out   out 16  current PC (byte address)
//          alu_out  out 16  combinational ALU result of the instruction at PC
module mips
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256,
  parameter logic [IMEM_WORDS*DATA_W-1:0] IMEM_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] alu_out
);

  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_WORDS);
  localparam logic [DATA_W-2:0] IMEM_LIMIT = IMEM_WORDS[DATA_W-2:0];

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] rom [IMEM_WORDS];

  logic [2**REG_W-1:0][DATA_W-1:0] regs;
  logic [DMEM_WORDS-1:0][DATA_W-1:0] dmem;

  logic [OP_W-1:0]    op;
  logic [REG_W-1:0]   rs, rt, rd, wr_reg;
  logic [FUNCT_W-1:0] funct;
  logic [DATA_W-1:0]  imm;
  logic [JADDR_W-1:0] jaddr;

  logic [DATA_W-1:0] rs_val, rt_val, alu_b, alu_result, wb_data;
  logic [DATA_W-1:0] pc_plus2, br_target, next_pc;
  logic [DA_W-1:0]   daddr;
  logic              alu_zero;

  alu_op_t alu_op;
  logic    alu_use_imm, reg_we, mem_to_reg, mem_we, is_beq, is_j;

  for (genvar i = 0; i < IMEM_WORDS; i++) begin : g_rom
    assign rom[i] = IMEM_INIT[i*DATA_W +: DATA_W];
  end

  // Words past the ROM read as 0, which decodes as add r0,r0,r0.
  assign instr = (pc[DATA_W-1:1] < IMEM_LIMIT) ? rom[pc[IA_W:1]] : '0;

  assign op    = instr[15:13];
  assign rs    = instr[12:10];
  assign rt    = instr[9:7];
  assign rd    = instr[6:4];
  assign funct = instr[2:0];
  assign imm   = sext_imm(instr[IMM_W-1:0]);
  assign jaddr = instr[JADDR_W-1:0];

  // r0 is never written and resets to 0, so plain indexing reads it as 0.
  assign rs_val = regs[rs];
  assign rt_val = regs[rt];

  always_comb begin
    alu_op      = ALU_ADD;
    alu_use_imm = 1'b0;
    reg_we      = 1'b0;
    wr_reg      = rt;
    mem_to_reg  = 1'b0;
    mem_we      = 1'b0;
    is_beq      = 1'b0;
    is_j        = 1'b0;
    case (op)
      OP_RTYPE: begin
        reg_we = 1'b1;
        wr_reg = rd;
        case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_XOR:  alu_op = ALU_XOR;
          default: alu_op = ALU_ADD;
        endcase
      end
      OP_ADDI: begin
        alu_use_imm = 1'b1;
        reg_we      = 1'b1;
      end
      OP_LW: begin
        alu_use_imm = 1'b1;
        reg_we      = 1'b1;
        mem_to_reg  = 1'b1;
      end
      OP_SW: begin
        alu_use_imm = 1'b1;
        mem_we      = 1'b1;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        is_beq = 1'b1;
      end
      OP_J: begin
        alu_op = ALU_PASS0;
        is_j   = 1'b1;
      end
      OP_SLTI: begin
        alu_op      = ALU_SLT;
        alu_use_imm = 1'b1;
        reg_we      = 1'b1;
      end
      default: alu_op = ALU_PASS0;
    endcase
  end

  assign alu_b = alu_use_imm ? imm : rt_val;

  mips_alu u_alu (
    .a      (rs_val),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Effective address bit 0 and bits above the RAM depth are dropped.
  assign daddr   = alu_result[DA_W:1];
  assign wb_data = mem_to_reg ? dmem[daddr] : alu_result;

  assign pc_plus2  = pc + 16'd2;
  assign br_target = pc_plus2 + {imm[DATA_W-2:0], 1'b0};

  always_comb begin
    next_pc = pc_plus2;
    if (is_j)
      next_pc = {pc_plus2[15:14], jaddr, 1'b0};
    else if (is_beq && alu_zero)
      next_pc = br_target;
  end

  // PC, register and RAM updates share one edge; LW in the same cycle as a
  // write to its address sees the pre-edge contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= '0;
      regs <= '0;
      dmem <= '0;
    end else begin
      pc <= next_pc;
      if (reg_we && (wr_reg != '0))
        regs[wr_reg] <= wb_data;
      if (mem_we)
        dmem[daddr] <= rt_val;
    end
  end

  assign pc_out  = pc;
  assign alu_out = alu_result;

endmodule

// File: tb/tb_mips.sv
// tb/tb_mips.sv - self-checking bench for the mips core against an ISA-level model
module tb_mips;

  localparam int IW = 256;
  localparam int DW = 256;

  function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rs,
                                        input logic [2:0] rt, input logic [6:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [15:0] enc_r(input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [2:0] rd, input logic [2:0] f);
    return {3'b000, rs, rt, rd, 1'b0, f};
  endfunction

  function automatic logic [15:0] enc_j(input logic [12:0] a);
    return {3'b101, a};
  endfunction

  // Directed prologue in words 0..15, pseudo-random code in 16..254, word 255 jumps to 16.
  function automatic logic [IW*16-1:0] gen_prog();
    logic [IW*16-1:0] p;
    logic [15:0] w;
    logic [31:0] s;
    logic [7:0]  t;
    p = '0;
    s = 32'h1234_5678;
    p[0*16 +: 16]  = enc_i(3'b001, 3'd0, 3'd1, 7'd5);
    p[1*16 +: 16]  = enc_i(3'b001, 3'd0, 3'd2, 7'd3);
    p[2*16 +: 16]  = enc_r(3'd1, 3'd2, 3'd3, 3'd0);
    p[3*16 +: 16]  = enc_r(3'd1, 3'd2, 3'd4, 3'd1);
    p[4*16 +: 16]  = enc_r(3'd2, 3'd1, 3'd5, 3'd4);
    p[5*16 +: 16]  = enc_i(3'b011, 3'd0, 3'd3, 7'd0);
    p[6*16 +: 16]  = enc_i(3'b010, 3'd0, 3'd6, 7'd0);
    p[7*16 +: 16]  = enc_r(3'd6, 3'd0, 3'd7, 3'd0);
    p[8*16 +: 16]  = enc_i(3'b100, 3'd1, 3'd1, 7'd2);
    p[9*16 +: 16]  = enc_i(3'b001, 3'd0, 3'd1, 7'd1);
    p[10*16 +: 16] = enc_j(13'd16);
    p[11*16 +: 16] = enc_i(3'b100, 3'd1, 3'd2, 7'd2);
    p[12*16 +: 16] = enc_i(3'b001, 3'd0, 3'd0, 7'd7);
    p[13*16 +: 16] = enc_r(3'd0, 3'd0, 3'd3, 3'd0);
    p[14*16 +: 16] = enc_j(13'd10);
    p[15*16 +: 16] = enc_i(3'b001, 3'd0, 3'd1, 7'd1);
    for (int i = 16; i < IW - 1; i++) begin
      s = s ^ (s << 13);
      s = s ^ (s >> 17);
      s = s ^ (s << 5);
      w = s[15:0];
      if (w[15:13] == 3'b100) begin
        if (i >= IW - 17) w[15:13] = 3'b001;
        else w[6:0] = {3'b000, s[19:16]};
      end else if (w[15:13] == 3'b101) begin
        if (s[25:24] != 2'b00) begin
          w[15:13] = 3'b000;
        end else begin
          t = (s[23:16] % 8'd239) + 8'd16;
          w = enc_j({5'b00000, t});
        end
      end
      p[i*16 +: 16] = w;
    end
    p[(IW-1)*16 +: 16] = enc_j(13'd16);
    return p;
  endfunction

  localparam logic [IW*16-1:0] PROG = gen_prog();

  // Hand-derived trace of the prologue: (pc, alu_out) right after each reset release.
  localparam logic [15:0] LIT_PC  [14] = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12,
                                           16'd14, 16'd16, 16'd22, 16'd24, 16'd26, 16'd28, 16'd20};
  localparam logic [15:0] LIT_ALU [14] = '{16'd5, 16'd3, 16'd8, 16'd2, 16'd1, 16'd0, 16'd0,
                                           16'd8, 16'd0, 16'd2, 16'd7, 16'd0, 16'd0, 16'd0};

  logic        clk;
  logic        rst;
  logic [15:0] pc_out;
  logic [15:0] alu_out;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc;
  logic [15:0] m_r   [8];
  logic [15:0] m_ram [DW];

  mips #(
    .IMEM_WORDS (IW),
    .DMEM_WORDS (DW),
    .IMEM_INIT  (PROG)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pc_out  (pc_out),
    .alu_out (alu_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = '0;
    foreach (m_r[i]) m_r[i] = '0;
    foreach (m_ram[i]) m_ram[i] = '0;
  endtask

  task automatic m_wr(input logic [2:0] idx, input logic [15:0] v);
    if (idx != 3'd0) m_r[idx] = v;
  endtask

  // Architectural meaning of the instruction at m_pc; commit applies its effects.
  task automatic m_exec(input bit commit, output logic [15:0] alu);
    logic [15:0] w, a, b, imm, ea, nxt, res;
    logic [2:0]  rs, rt, rd;
    w   = (m_pc >= 16'(2*IW)) ? 16'h0000 : PROG[int'(m_pc[8:1])*16 +: 16];
    rs  = w[12:10];
    rt  = w[9:7];
    rd  = w[6:4];
    a   = m_r[rs];
    b   = m_r[rt];
    imm = {{9{w[6]}}, w[6:0]};
    ea  = a + imm;
    nxt = m_pc + 16'd2;
    res = '0;
    case (w[15:13])
      3'd0: begin
        case (w[2:0])
          3'd1:    res = a - b;
          3'd2:    res = a & b;
          3'd3:    res = a | b;
          3'd4:    res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
          3'd5:    res = a ^ b;
          default: res = a + b;
        endcase
        if (commit) m_wr(rd, res);
      end
      3'd1: begin res = ea; if (commit) m_wr(rt, ea); end
      3'd2: begin res = ea; if (commit) m_wr(rt, m_ram[ea[8:1]]); end
      3'd3: begin res = ea; if (commit) m_ram[ea[8:1]] = b; end
      3'd4: begin res = a - b; if (a == b) nxt = nxt + (imm << 1); end
      3'd5: nxt = {nxt[15:14], w[12:0], 1'b0};
      3'd6: begin
        res = ($signed(a) < $signed(imm)) ? 16'd1 : 16'd0;
        if (commit) m_wr(rt, res);
      end
      default: ;
    endcase
    alu = res;
    if (commit) m_pc = nxt;
  endtask

  task automatic compare();
    logic [15:0] e;
    m_exec(1'b0, e);
    check("pc", pc_out, m_pc);
    check("alu", alu_out, e);
  endtask

  task automatic cycle();
    logic [15:0] d;
    @(posedge clk);
    if (rst) m_reset();
    else m_exec(1'b1, d);
    @(negedge clk);
    compare();
  endtask

  task automatic check_lit(input int k);
    logic [15:0] e;
    m_exec(1'b0, e);
    check("lit_pc", pc_out, LIT_PC[k]);
    check("lit_alu", alu_out, LIT_ALU[k]);
    check("lit_model_pc", m_pc, LIT_PC[k]);
    check("lit_model_alu", e, LIT_ALU[k]);
  endtask

  // Called shortly after rst falls, before the next rising edge.
  task automatic run(input int n);
    #1;
    compare();
    check_lit(0);
    for (int k = 1; k < n; k++) begin
      cycle();
      if (k < 14) check_lit(k);
      if (k == 14) check("lit_pc_after_jumps", pc_out, 16'd32);
    end
  endtask

  initial begin
    rst = 1'b1;
    m_reset();
    repeat (10) begin
      @(negedge clk);
      compare();
      check("reset_pc", pc_out, 16'd0);
      check("reset_alu", alu_out, 16'd5);
    end
    #2 rst = 1'b0;
    run(1500);
    for (int r = 0; r < 6; r++) begin
      #($urandom_range(1, 3));
      rst = 1'b1;
      #1;
      check("async_rst_pc", pc_out, 16'd0);
      check("async_rst_alu", alu_out, 16'd5);
      m_reset();
      repeat ($urandom_range(1, 4)) cycle();
      #($urandom_range(1, 3));
      rst = 1'b0;
      run($urandom_range(100, 800));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
